// File: rtl/sevenseg_scan_decoder.sv
// Recovers the value shown on a multiplexed 7-segment display by sampling each
// settled anode phase, assembling whole frames and publishing a frame once it repeats.
module sevenseg_scan_decoder #(
  parameter int NDIGIT        = 3,
  parameter int SETTLE        = 16,
  parameter int STABLE_FRAMES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [6:0]            seg_in,
  input  logic [NDIGIT-1:0]     anode_in,
  output logic [4*NDIGIT-1:0]   BCD,
  output logic                  valid,
  output logic                  err,
  output logic                  dbg_state,
  output logic [NDIGIT-1:0]     dbg_mask
);

  localparam int CW = $clog2(SETTLE);
  localparam int MW = (STABLE_FRAMES > 1) ? $clog2(STABLE_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_HIT   = CW'(SETTLE - 2);
  localparam logic [CW-1:0] CNT_MAX   = CW'(SETTLE - 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(STABLE_FRAMES - 1);

  typedef enum logic {COLLECT = 1'b0, CHECK = 1'b1} state_t;

  state_t                state, state_next;
  logic [6:0]            seg_s1, seg_s2;
  logic [NDIGIT-1:0]     an_s1, an_s2, an_prev;
  logic [CW-1:0]         cnt;
  logic [NDIGIT-1:0]     mask;
  logic                  bad;
  logic                  first;
  logic [MW-1:0]         match, match_new;
  logic [4*NDIGIT-1:0]   frame_buf, prev;
  logic                  an_onehot, an_steady, sample;
  logic [4:0]            dec;
  logic                  same_prev, update;

  // {legal, digit}; blank decodes to F, anything outside the table is illegal.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b0111111: decode = {1'b1, 4'd0};
      7'b0000110: decode = {1'b1, 4'd1};
      7'b1011011: decode = {1'b1, 4'd2};
      7'b1001111: decode = {1'b1, 4'd3};
      7'b1100110: decode = {1'b1, 4'd4};
      7'b1101101: decode = {1'b1, 4'd5};
      7'b1111101: decode = {1'b1, 4'd6};
      7'b0000111: decode = {1'b1, 4'd7};
      7'b1111111: decode = {1'b1, 4'd8};
      7'b1101111: decode = {1'b1, 4'd9};
      7'b0000000: decode = {1'b1, 4'hF};
      default:    decode = {1'b0, 4'hF};
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      seg_s1  <= '0;
      seg_s2  <= '0;
      an_s1   <= '0;
      an_s2   <= '0;
      an_prev <= '0;
    end else begin
      seg_s1  <= seg_in;
      seg_s2  <= seg_s1;
      an_s1   <= anode_in;
      an_s2   <= an_s1;
      an_prev <= an_s2;
    end
  end

  // Sampling fires on the edge the counter steps into SETTLE-1, then it parks there.
  always_comb begin
    an_onehot = $onehot(an_s2);
    an_steady = an_onehot && (an_s2 == an_prev);
    sample    = en && an_steady && (cnt == CNT_HIT);
    dec       = decode(seg_s2);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!en || !an_steady) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= COLLECT;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (sample && (&(mask | an_s2))) state_next = CHECK;
      CHECK:   state_next = COLLECT;
    endcase
  end

  always_comb begin
    same_prev = (frame_buf == prev);
    match_new = '0;
    if (!bad && same_prev) match_new = (match == MATCH_MAX) ? match : match + 1'b1;
    update = (state == CHECK) && !bad && (match_new == MATCH_MAX) &&
             ((frame_buf != BCD) || first);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_buf <= '0;
      mask      <= '0;
      bad       <= 1'b0;
      match     <= '0;
      prev      <= '0;
      first     <= 1'b1;
      BCD       <= '0;
      valid     <= 1'b0;
      err       <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      case (state)
        COLLECT: begin
          if (sample) begin
            for (int i = 0; i < NDIGIT; i++) begin
              if (an_s2[i]) frame_buf[4*i +: 4] <= dec[3:0];
            end
            mask <= mask | an_s2;
            if (!dec[4]) bad <= 1'b1;
          end
        end
        CHECK: begin
          mask  <= '0;
          bad   <= 1'b0;
          match <= match_new;
          if (bad)             err  <= 1'b1;
          else if (!same_prev) prev <= frame_buf;
          if (update) begin
            BCD   <= frame_buf;
            valid <= 1'b1;
            first <= 1'b0;
          end
        end
      endcase
    end
  end

  assign dbg_state = (state == CHECK);
  assign dbg_mask  = mask;

endmodule

// File: doc/sevenseg_scan_decoder.md
SEVENSEG_SCAN_DECODER -- requirements
Module: sevenseg_scan_decoder

Interface
REQ-001 The block SHALL have the parameter NDIGIT, default 3, giving the number of multiplexed digits.
REQ-002 The block SHALL have the parameter SETTLE, default 16, giving the consecutive cycles an anode must hold before sampling (minimum 2).
REQ-003 The block SHALL have the parameter STABLE_FRAMES, default 2, giving the consecutive identical frames required before output update (minimum 1).
REQ-004 The block SHALL have one clock and synchronous active-low reset, with ports: clk, input, 1 bit, single clock; rst, input, 1 bit, synchronous active-low reset.
REQ-005 The block SHALL have the port en, input, 1 bit: capture enable.
REQ-006 The block SHALL have the port seg_in, input, 7 bits, {G,F,E,D,C,B,A}: segment lines, active-high, asynchronous to clk.
REQ-007 The block SHALL have the port anode_in, input, NDIGIT bits: digit select, active-high, bit 0 = least significant digit, asynchronous.
REQ-008 The block SHALL have the port BCD, output, 4*NDIGIT bits: captured value, digit i in BCD[4i+3:4i].
REQ-009 The block SHALL have the port valid, output, 1 bit: one-cycle pulse when BCD is updated.
REQ-010 The block SHALL have the port err, output, 1 bit: one-cycle pulse when a frame is discarded for an illegal pattern.

Function
REQ-011 seg_in and anode_in SHALL each pass through a two-flop synchronizer before any other use.
REQ-012 A synchronized anode value with exactly one bit set SHALL select digit index k; zero or more than one bit set SHALL mean idle (no sampling, settle counter cleared).
REQ-013 The settle counter SHALL count consecutive cycles with an unchanged one-hot anode value, and SHALL restart at 0 on any change.
REQ-014 The synchronized seg value SHALL be sampled exactly once per anode phase, on the cycle the counter reaches SETTLE-1.
REQ-015 The first sample after a pin change SHALL occur SETTLE+2 cycles after that change.
REQ-016 Sampled patterns SHALL decode as: 0111111->0, 0000110->1, 1011011->2, 1001111->3, 1100110->4, 1101101->5, 1111101->6, 0000111->7, 1111111->8, 1101111->9, 0000000->F (blank).
REQ-017 Any other pattern SHALL be illegal and SHALL mark the current frame bad.
REQ-018 The frame FSM SHALL have the states COLLECT and CHECK.
REQ-019 In COLLECT, each sample SHALL write digit k of a frame buffer and set bit k of a capture mask, and a re-sample of an already-captured digit SHALL overwrite it.
REQ-020 The cycle the mask becomes all ones, including via the completing sample, the FSM SHALL go to CHECK for exactly one cycle, then return to COLLECT with the mask cleared and the bad flag cleared.
REQ-021 In CHECK with a bad frame, the block SHALL pulse err, leave the previous-frame register unchanged, and zero the match counter.
REQ-022 In CHECK with a good frame identical to the previous-frame register, the match counter SHALL increment, saturating at STABLE_FRAMES-1.
REQ-023 In CHECK with a good frame that differs from the previous-frame register, the match counter SHALL be set to 0 and the frame SHALL be stored as previous.
REQ-024 When a good frame leaves the match counter at STABLE_FRAMES-1, and either that frame differs from BCD or no update has occurred since reset, BCD SHALL be loaded with it and valid SHALL pulse, both registered one cycle after CHECK.
REQ-025 With STABLE_FRAMES=1, every good frame whose value differs from BCD SHALL update BCD.
REQ-026 An unchanged stable value SHALL NOT re-pulse valid.
REQ-027 With en low, the synchronizers SHALL keep running.
REQ-028 With en low, the settle counter SHALL be held at 0 and no sampling SHALL occur.
REQ-029 With en low, the FSM, mask and frame buffer SHALL hold, and BCD SHALL hold.
REQ-030 Deasserting en SHALL NOT discard a partial frame.
REQ-031 valid and err SHALL never assert in the same cycle, and SHALL never assert on consecutive cycles.

Reset
REQ-032 With rst low at a clk edge, the block SHALL set: BCD=0, valid=0, err=0, synchronizers=0, settle counter=0, mask=0, bad flag=0, match counter=0, previous-frame register=0, FSM=COLLECT, and the first-update flag set.
REQ-033 A reset mid-frame or mid-CHECK SHALL discard all partial state, and the next update SHALL require STABLE_FRAMES full good frames.

Verification
REQ-034 With NDIGIT=3, SETTLE=4, STABLE_FRAMES=2, driving digits 3,2,1 on anodes 001,010,100 for 10 cycles each, repeated, SHALL give BCD=12'h123 with one valid pulse after the second frame's CHECK, and no further pulses.
REQ-035 While stable at 12'h123, one frame showing 124 followed by 123 SHALL leave BCD unchanged with no valid pulse; two consecutive 124 frames SHALL give BCD=12'h124 with one valid pulse.
REQ-036 Pattern 1000000 on digit 1 for one frame SHALL produce one err pulse, no valid pulse, and a zeroed match counter, and the next two good 123 frames SHALL update BCD.
REQ-037 An anode held only 3 cycles (less than SETTLE) or anode_in=011 for 10 cycles SHALL cause no sample, and the mask SHALL stay incomplete with no CHECK.
REQ-038 Reset asserted after two digits of a frame SHALL give BCD=0 and mask=0, and 12'h456 SHALL then require two full frames before valid.
REQ-039 en dropped for 50 cycles mid-frame, then raised, SHALL complete the frame with the held mask, giving the correct BCD.
